rect_fill_writer: RTL

- Drawing-side writer for the display frame buffer.
- Accepts a filled-rectangle command (origin, size, colour) over a valid/ready handshake.
- Emits one frame-buffer write per clock until the rectangle, clipped to the buffer bounds, is filled.
- Sits between the game/graphics command logic and the frame buffer write port. Screen clears use a full-size rectangle.

---
 rtl/buffer_config_pkg.sv | 18 +
 rtl/rect_fill_writer_if.sv | 38 +++
 rtl/rect_fill_writer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/buffer_config_pkg.sv
// Frame buffer geometry shared by the frame buffer and the blocks that write into it.
package buffer_config_pkg;

  typedef struct packed {
    int unsigned width;
    int unsigned height;
    int unsigned addr_width;
    int unsigned data_width;
  } buffer_config_t;

  localparam buffer_config_t BUFFER_160x120x12 = '{
    width:      160,
    height:     120,
    addr_width: 15,
    data_width: 12
  };

endpackage

// File: rtl/rect_fill_writer_if.sv
// Command handshake and frame-buffer write port of the rectangle fill writer.
interface rect_fill_writer_if #(
  parameter buffer_config_pkg::buffer_config_t CFG = buffer_config_pkg::BUFFER_160x120x12
) ();

  localparam int unsigned XW = $clog2(CFG.width);
  localparam int unsigned YW = $clog2(CFG.height);
  localparam int unsigned WW = $clog2(CFG.width + 1);
  localparam int unsigned HW = $clog2(CFG.height + 1);
  localparam int unsigned AW = CFG.addr_width;
  localparam int unsigned DW = CFG.data_width;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [XW-1:0] cmd_x;
  logic [YW-1:0] cmd_y;
  logic [WW-1:0] cmd_w;
  logic [HW-1:0] cmd_h;
  logic [DW-1:0] cmd_color;
  logic          busy;
  logic          done;
  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;

  // Command source / write-port observer side.
  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, busy, done, write_en, write_addr, write_data
  );

  // Writer side.
  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, busy, done, write_en, write_addr, write_data
  );

endinterface

// File: rtl/rect_fill_writer.sv
// Fills a clipped rectangle in the frame buffer, one pixel write per clock in raster order.
module rect_fill_writer
  import buffer_config_pkg::*;
#(
  parameter buffer_config_t BUFFER_CONFIG = BUFFER_160x120x12
) (
  input  logic                clk,
  input  logic                rstn,
  rect_fill_writer_if.slave   bus
);

  localparam int unsigned Width  = BUFFER_CONFIG.width;
  localparam int unsigned Height = BUFFER_CONFIG.height;
  localparam int unsigned XW     = $clog2(Width);
  localparam int unsigned YW     = $clog2(Height);
  localparam int unsigned WW     = $clog2(Width + 1);
  localparam int unsigned HW     = $clog2(Height + 1);
  localparam int unsigned AW     = BUFFER_CONFIG.addr_width;
  localparam int unsigned DW     = BUFFER_CONFIG.data_width;

  localparam logic [XW:0]   WidthX  = (XW + 1)'(Width);
  localparam logic [YW:0]   HeightY = (YW + 1)'(Height);
  localparam logic [AW-1:0] WidthA  = AW'(Width);

  typedef enum logic [1:0] {StIdle, StSetup, StFill, StDone} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [WW-1:0] w_q, w_d;
  logic [HW-1:0] h_q, h_d;
  logic [DW-1:0] color_q, color_d;
  logic [XW:0]   x_end_q, x_end_d;
  logic [YW:0]   y_end_q, y_end_d;
  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic          done_q, done_d;
  logic          write_en_q, write_en_d;
  logic [AW-1:0] write_addr_q, write_addr_d;

  logic [XW:0]   x_sum, col_inc;
  logic [YW:0]   y_sum, row_inc;
  logic [AW-1:0] setup_base;
  logic          empty, last_col, last_row;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    w_d          = w_q;
    h_d          = h_q;
    color_d      = color_q;
    x_end_d      = x_end_q;
    y_end_d      = y_end_q;
    col_d        = col_q;
    row_d        = row_q;
    row_base_d   = row_base_q;
    done_d       = 1'b0;
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;

    // Sums are one bit wider than the coordinate so they cannot wrap.
    x_sum      = (XW + 1)'(x_q) + (XW + 1)'(w_q);
    y_sum      = (YW + 1)'(y_q) + (YW + 1)'(h_q);
    col_inc    = (XW + 1)'(col_q) + (XW + 1)'(1);
    row_inc    = (YW + 1)'(row_q) + (YW + 1)'(1);
    last_col   = (col_inc == x_end_q);
    last_row   = (row_inc == y_end_q);
    empty      = (w_q == '0) || (h_q == '0) ||
                 ((XW + 1)'(x_q) >= WidthX) || ((YW + 1)'(y_q) >= HeightY);
    // Only multiply in the whole design; the fill loop steps row_base with an adder.
    setup_base = AW'(y_q) * WidthA;

    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          x_d     = bus.cmd_x;
          y_d     = bus.cmd_y;
          w_d     = bus.cmd_w;
          h_d     = bus.cmd_h;
          color_d = bus.cmd_color;
          state_d = StSetup;
        end
      end
      StSetup: begin
        x_end_d = (x_sum > WidthX) ? WidthX : x_sum;
        y_end_d = (y_sum > HeightY) ? HeightY : y_sum;
        if (empty) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          col_d        = x_q;
          row_d        = y_q;
          row_base_d   = setup_base;
          write_en_d   = 1'b1;
          write_addr_d = setup_base + AW'(x_q);
          state_d      = StFill;
        end
      end
      StFill: begin
        if (last_col && last_row) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else if (last_col) begin
          col_d        = x_q;
          row_d        = row_inc[YW-1:0];
          row_base_d   = row_base_q + WidthA;
          write_en_d   = 1'b1;
          write_addr_d = row_base_q + WidthA + AW'(x_q);
        end else begin
          col_d        = col_inc[XW-1:0];
          write_en_d   = 1'b1;
          write_addr_d = write_addr_q + AW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      color_q      <= '0;
      x_end_q      <= '0;
      y_end_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      done_q       <= 1'b0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      w_q          <= w_d;
      h_q          <= h_d;
      color_q      <= color_d;
      x_end_q      <= x_end_d;
      y_end_q      <= y_end_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_base_q   <= row_base_d;
      done_q       <= done_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
    end
  end

  assign bus.cmd_ready  = (state_q == StIdle);
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = done_q;
  assign bus.write_en   = write_en_q;
  assign bus.write_addr = write_addr_q;
  assign bus.write_data = color_q;

endmodule
